acc_burst_arbiter: RTL

Shares a single internal WIDTH-bit accumulator among NREQ requesters. Each requester streams a burst of operands, and the last beat is marked. The block sequences clear, accumulate and result-handoff for one burst at a time. Requesters are served round-robin. The result is presented on a valid/ready port with requester ID, beat count and sticky overflow flag. It sits between operand producers and the consumer of accumulated sums.

---
 rtl/acc_burst_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/acc_burst_arbiter.sv
// Round-robin arbiter sharing one accumulator among NREQ burst requesters.
// Result is handed off on a valid/ready port with id, beat count and overflow.
module acc_burst_arbiter #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 2,
  parameter  int CNT_W = 4,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [ID_W-1:0]       res_id,
  output logic [CNT_W-1:0]      res_cnt,
  output logic                  res_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic [ID_W-1:0]  grant, grant_n;
  logic [ID_W-1:0]  ptr, ptr_n;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic [WIDTH-1:0] ops [NREQ];
  logic [WIDTH:0]   sum;
  logic             hs;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ops[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // two passes: from ptr upward first, then wrap to indices below ptr
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && ID_W'(i) >= ptr) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && ID_W'(i) < ptr) begin
        pick  = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign hs  = (state == ACC) && req_valid[grant];
  assign sum = {1'b0, acc} + {1'b0, ops[grant]};

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
    grant_n = grant;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_n = pick;
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          state_n = ACC;
        end
      end
      ACC: begin
        if (hs) begin
          acc_n = sum[WIDTH-1:0];
          ovf_n = ovf | sum[WIDTH];
          if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
          if (req_last[grant]) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          ptr_n   = (grant == ID_W'(NREQ-1)) ? '0 : grant + 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ACC) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = acc;
  assign res_id    = grant;
  assign res_cnt   = cnt;
  assign res_ovf   = ovf;

endmodule
